// File: rtl/snake_turn_scheduler.sv
// Snake turn scheduler: queues key-pulse turn requests in a small circular
// buffer and commits at most one direction change per game step (tick).
// Turns are validated against the last scheduled direction so reversals and
// duplicates are dropped silently, while quick double-taps survive.
module snake_turn_scheduler #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_pulse,
  input  logic          down_pulse,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          tick,
  input  logic          flush,
  output logic [1:0]    dir,
  output logic [CW-1:0] pending,
  output logic          drop
);

  // Pointer width; a single-entry queue still needs a one-bit pointer.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  logic [1:0]    queue_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_prev;

  logic          cand_valid;
  logic [1:0]    cand;
  logic [1:0]    ref_dir;
  logic          accept;
  logic          pop;
  logic          room;
  logic          push;

  // Advance a pointer around the circular buffer.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = '0;
    else                     next_ptr = p + 1'b1;
  endfunction

  // Pick one candidate key per cycle; lower-priority keys are discarded.
  always_comb begin
    cand_valid = 1'b1;
    cand       = DIR_RIGHT;
    if (up_pulse)         cand = DIR_UP;
    else if (left_pulse)  cand = DIR_LEFT;
    else if (down_pulse)  cand = DIR_DOWN;
    else if (right_pulse) cand = DIR_RIGHT;
    else                  cand_valid = 1'b0;
  end

  // Validate the candidate against the last scheduled direction and decide
  // whether it fits, counting the slot freed by a same-cycle pop.
  always_comb begin
    tail_prev = (tail == '0) ? PW'(DEPTH - 1) : tail - 1'b1;
    ref_dir   = (pending != '0) ? queue_mem[tail_prev] : dir;
    accept    = cand_valid && (cand != ref_dir) &&
                (cand != {ref_dir[1], ~ref_dir[0]});
    pop       = tick && (pending != '0);
    room      = (pending < CW'(DEPTH)) || pop;
    push      = accept && room;
  end

  // Queue storage needs no reset; occupancy is tracked by pending.
  always_ff @(posedge clk) begin
    if (push) queue_mem[tail] <= cand;
  end

  // Pointers, occupancy, committed direction and the overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head    <= '0;
      tail    <= '0;
      pending <= '0;
      dir     <= DIR_RIGHT;
      drop    <= 1'b0;
    end else begin
      drop <= accept && !room;
      if (pop) begin
        dir  <= queue_mem[head];
        head <= next_ptr(head);
      end
      if (push) tail <= next_ptr(tail);
      if (push && !pop)      pending <= pending + 1'b1;
      else if (pop && !push) pending <= pending - 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_turn_scheduler.sv
// Self-checking bench for snake_turn_scheduler: directed scenarios followed
// by random key/tick traffic, compared against a queue-based reference model.
module tb_snake_turn_scheduler;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_pulse, down_pulse, left_pulse, right_pulse;
  logic          tick, flush;
  logic [1:0]    dir;
  logic [CW-1:0] pending;
  logic          drop;

  int vectors = 0;
  int errors  = 0;

  logic [1:0] model_q [$];
  logic [1:0] exp_dir;
  logic       exp_drop;
  int         exp_pending;

  snake_turn_scheduler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .left_pulse (left_pulse),
    .right_pulse(right_pulse),
    .tick       (tick),
    .flush      (flush),
    .dir        (dir),
    .pending    (pending),
    .drop       (drop)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference behaviour for one clock edge, written from the turn rules.
  task automatic model_step(input logic u, l, d, r, t, f, rn);
    logic [1:0] c, rf, opp;
    bit has_c, ok, has_room;
    if (!rn || f) begin
      model_q.delete();
      exp_dir  = 2'b00;
      exp_drop = 1'b0;
    end else begin
      has_c = 1;
      if (u)      c = 2'b10;
      else if (l) c = 2'b01;
      else if (d) c = 2'b11;
      else if (r) c = 2'b00;
      else begin has_c = 0; c = 2'b00; end
      rf       = (model_q.size() > 0) ? model_q[$] : exp_dir;
      opp      = {rf[1], ~rf[0]};
      ok       = has_c && (c != rf) && (c != opp);
      has_room = (model_q.size() < DEPTH) || (t && model_q.size() > 0);
      if (t && model_q.size() > 0) exp_dir = model_q.pop_front();
      if (ok && has_room) model_q.push_back(c);
      exp_drop = ok && !has_room;
    end
    exp_pending = model_q.size();
  endtask

  // Compare all outputs against the model.
  task automatic check_output(input string tag);
    vectors++;
    assert (dir === exp_dir) else begin
      errors++;
      $error("[TB] FAIL %s dir: got %b expected %b", tag, dir, exp_dir);
    end
    vectors++;
    assert (pending === CW'(exp_pending)) else begin
      errors++;
      $error("[TB] FAIL %s pending: got %0d expected %0d", tag, pending, exp_pending);
    end
    vectors++;
    assert (drop === exp_drop) else begin
      errors++;
      $error("[TB] FAIL %s drop: got %b expected %b", tag, drop, exp_drop);
    end
  endtask

  // Drive one cycle of inputs, advance model, release inputs, then check.
  task automatic apply_stimulus(input logic u, l, d, r, t, f, rn, input string tag);
    up_pulse = u; left_pulse = l; down_pulse = d; right_pulse = r;
    tick = t; flush = f; rst_n = rn;
    @(posedge clk);
    model_step(u, l, d, r, t, f, rn);
    #1;
    up_pulse = 0; left_pulse = 0; down_pulse = 0; right_pulse = 0;
    tick = 0; flush = 0; rst_n = 1;
    check_output(tag);
  endtask

  initial begin
    up_pulse = 0; down_pulse = 0; left_pulse = 0; right_pulse = 0;
    tick = 0; flush = 0; rst_n = 0;
    #2;
    // Reset and idle ticks.
    apply_stimulus(0,0,0,0,0,0,0, "reset0");
    apply_stimulus(0,0,0,0,0,0,0, "reset1");
    for (int i = 0; i < 3; i++) apply_stimulus(0,0,0,0,1,0,1, "idle_tick");
    // Single up turn, committed by a tick.
    apply_stimulus(1,0,0,0,0,0,1, "up_push");
    apply_stimulus(0,0,0,0,1,0,1, "up_commit");
    // Back to RIGHT via reset, then reversal and duplicate rejected.
    apply_stimulus(0,0,0,0,0,0,0, "reset2");
    apply_stimulus(0,1,0,0,0,0,1, "reverse_rej");
    apply_stimulus(0,0,0,1,0,0,1, "dup_rej");
    // Double tap up then left, two ticks.
    apply_stimulus(1,0,0,0,0,0,1, "dbl_up");
    apply_stimulus(0,1,0,0,0,0,1, "dbl_left");
    apply_stimulus(0,0,0,0,1,0,1, "dbl_tick1");
    apply_stimulus(0,0,0,0,1,0,1, "dbl_tick2");
    // Down after up queued is a reversal of the scheduled direction.
    apply_stimulus(0,0,0,0,0,0,0, "reset3");
    apply_stimulus(1,0,0,0,0,0,1, "up_q");
    apply_stimulus(0,0,1,0,0,0,1, "down_rej");
    // Full queue: drop, then the same key with a tick fits.
    apply_stimulus(0,1,0,0,0,0,1, "fill_left");
    apply_stimulus(0,0,1,0,0,0,1, "full_drop");
    apply_stimulus(0,0,0,0,0,0,1, "drop_clear");
    apply_stimulus(0,0,1,0,1,0,1, "push_pop");
    // Flush wins over tick and keys.
    apply_stimulus(1,0,0,0,1,1,1, "flush");
    // Simultaneous keys: up has priority over right.
    apply_stimulus(1,0,0,1,0,0,1, "prio_up");
    apply_stimulus(0,1,1,0,0,0,1, "prio_left");
    apply_stimulus(0,0,0,0,1,0,1, "prio_tick");
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom % 4) == 0, ($urandom % 4) == 0,
                     ($urandom % 4) == 0, ($urandom % 4) == 0,
                     ($urandom % 3) == 0, ($urandom % 40) == 0,
                     ($urandom % 60) != 0, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
